// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite slave register file: independent write (AW/W/B) and read (AR/R) engines,
// one outstanding transaction per direction, byte-strobed writes, SLVERR on unmapped addresses.
module axi4lite_slave_regfile #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } wstate_t;
  typedef enum logic { R_IDLE, R_DATA } rstate_t;

  function automatic logic addr_mapped(input logic [ADDR_WIDTH-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] strb_merge(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] m;
    m = old_val;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) m[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return m;
  endfunction

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  wstate_t               r_wstate, w_wstate_nxt;
  logic                  r_aw_held, w_aw_held_nxt;
  logic                  r_w_held, w_w_held_nxt;
  logic [ADDR_WIDTH-1:0] r_awaddr, w_awaddr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [STRB_W-1:0]     r_wstrb, w_wstrb_nxt;
  logic                  r_awready, w_awready_nxt;
  logic                  r_wready, w_wready_nxt;
  logic                  r_bvalid, w_bvalid_nxt;
  logic [1:0]            r_bresp, w_bresp_nxt;
  logic                  w_commit;

  rstate_t               r_rstate, w_rstate_nxt;
  logic                  r_ar_held, w_ar_held_nxt;
  logic [ADDR_WIDTH-1:0] r_araddr, w_araddr_nxt;
  logic                  r_arready, w_arready_nxt;
  logic                  r_rvalid, w_rvalid_nxt;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic [1:0]            r_rresp, w_rresp_nxt;
  logic [DATA_WIDTH-1:0] w_rd_val;

  // Write engine: AW and W are captured independently; commit happens once both are held.
  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_aw_held_nxt = r_aw_held;
    w_w_held_nxt  = r_w_held;
    w_awaddr_nxt  = r_awaddr;
    w_wdata_nxt   = r_wdata;
    w_wstrb_nxt   = r_wstrb;
    w_awready_nxt = r_awready;
    w_wready_nxt  = r_wready;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    w_commit      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (r_aw_held && r_w_held) begin
          w_commit      = 1'b1;
          w_bvalid_nxt  = 1'b1;
          w_bresp_nxt   = addr_mapped(r_awaddr) ? RESP_OKAY : RESP_SLVERR;
          w_awready_nxt = 1'b0;
          w_wready_nxt  = 1'b0;
          w_wstate_nxt  = W_RESP;
        end else begin
          if (s_awvalid && r_awready) begin
            w_aw_held_nxt = 1'b1;
            w_awaddr_nxt  = s_awaddr;
          end
          if (s_wvalid && r_wready) begin
            w_w_held_nxt = 1'b1;
            w_wdata_nxt  = s_wdata;
            w_wstrb_nxt  = s_wstrb;
          end
          w_awready_nxt = !w_aw_held_nxt;
          w_wready_nxt  = !w_w_held_nxt;
        end
      end
      W_RESP: begin
        if (s_bready) begin
          w_bvalid_nxt  = 1'b0;
          w_aw_held_nxt = 1'b0;
          w_w_held_nxt  = 1'b0;
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
          w_wstate_nxt  = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_awaddr  <= w_awaddr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wstrb   <= w_wstrb_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
    end
  end

  // Unmapped addresses match no index, so they leave every register untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == int'(r_awaddr)) r_regs[i] <= strb_merge(r_regs[i], r_wdata, r_wstrb);
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == int'(r_araddr)) w_rd_val = r_regs[i];
    end
  end

  // Read engine: the address is latched first and data sampled on the following edge,
  // so a write committing on that same edge is not yet visible to the read.
  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_ar_held_nxt = r_ar_held;
    w_araddr_nxt  = r_araddr;
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    case (r_rstate)
      R_IDLE: begin
        if (s_arvalid && r_arready) begin
          w_araddr_nxt  = s_araddr;
          w_ar_held_nxt = 1'b1;
          w_arready_nxt = 1'b0;
          w_rstate_nxt  = R_DATA;
        end else begin
          w_arready_nxt = 1'b1;
        end
      end
      R_DATA: begin
        if (r_ar_held) begin
          w_ar_held_nxt = 1'b0;
          w_rvalid_nxt  = 1'b1;
          w_rdata_nxt   = addr_mapped(r_araddr) ? w_rd_val : '0;
          w_rresp_nxt   = addr_mapped(r_araddr) ? RESP_OKAY : RESP_SLVERR;
        end else if (s_rready) begin
          w_rvalid_nxt  = 1'b0;
          w_arready_nxt = 1'b1;
          w_rstate_nxt  = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_ar_held <= 1'b0;
      r_araddr  <= '0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= '0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_ar_held <= w_ar_held_nxt;
      r_araddr  <= w_araddr_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
    end
  end

  assign s_awready = r_awready;
  assign s_wready  = r_wready;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_arready = r_arready;
  assign s_rvalid  = r_rvalid;
  assign s_rdata   = r_rdata;
  assign s_rresp   = r_rresp;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    assign regs_flat[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
  end

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Scoreboard bench for axi4lite_slave_regfile with three implemented registers (address 3 unmapped).
module tb_axi4lite_slave_regfile;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int NR = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW-1:0]   s_awaddr = '0;
  logic            s_awvalid = 1'b0;
  logic            s_awready;
  logic [DW-1:0]   s_wdata = '0;
  logic [DW/8-1:0] s_wstrb = '0;
  logic            s_wvalid = 1'b0;
  logic            s_wready;
  logic [1:0]      s_bresp;
  logic            s_bvalid;
  logic            s_bready = 1'b1;
  logic [AW-1:0]   s_araddr = '0;
  logic            s_arvalid = 1'b0;
  logic            s_arready;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rvalid;
  logic            s_rready = 1'b1;
  logic [NR*DW-1:0] regs_flat;

  axi4lite_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .regs_flat(regs_flat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] mdl [NR];
  logic [1:0]    qb [$];
  logic [9:0]    qr [$];
  logic [1:0]    mon_b;
  logic [9:0]    mon_r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] mdl_flat();
    return {mdl[2], mdl[1], mdl[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expectations are pushed at issue time; reads see the model before the write they race with.
  task automatic push_read(input logic [AW-1:0] a);
    if (int'(a) < NR) qr.push_back({2'b00, mdl[a]});
    else              qr.push_back({2'b10, 8'h00});
  endtask

  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic s);
    if (int'(a) < NR) begin
      qb.push_back(2'b00);
      if (s) mdl[a] = d;
    end else begin
      qb.push_back(2'b10);
    end
  endtask

  task automatic issue(input bit do_wr, input bit do_rd, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic ws, input logic [AW-1:0] ra);
    bit aw_ok, w_ok, ar_ok, done;
    if (do_rd) push_read(ra);
    if (do_wr) push_write(wa, wd, ws);
    s_awaddr = wa; s_wdata = wd; s_wstrb = ws; s_araddr = ra;
    s_awvalid = do_wr; s_wvalid = do_wr; s_arvalid = do_rd;
    done = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (!s_awvalid && !s_wvalid && !s_arvalid) begin done = 1'b1; break; end
      aw_ok = s_awvalid && s_awready;
      w_ok  = s_wvalid && s_wready;
      ar_ok = s_arvalid && s_arready;
      tick();
      if (aw_ok) s_awvalid = 1'b0;
      if (w_ok)  s_wvalid  = 1'b0;
      if (ar_ok) s_arvalid = 1'b0;
    end
    if (!done) chk("issue_timeout", 0, 1);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (qb.size() == 0 && qr.size() == 0 && !s_bvalid && !s_rvalid && s_awready && s_arready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_bvalid();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (s_bvalid) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) chk("bvalid_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (s_bvalid && s_bready) begin
        if (qb.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          mon_b = qb.pop_front();
          chk("bresp", 32'(s_bresp), 32'(mon_b));
        end
      end
      if (s_rvalid && s_rready) begin
        if (qr.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          mon_r = qr.pop_front();
          chk("rdata", 32'(s_rdata), 32'(mon_r[7:0]));
          chk("rresp", 32'(s_rresp), 32'(mon_r[9:8]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) mdl[i] = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_awready", 32'(s_awready), 0);
    chk("rst_wready",  32'(s_wready),  0);
    chk("rst_arready", 32'(s_arready), 0);
    chk("rst_bvalid",  32'(s_bvalid),  0);
    chk("rst_rvalid",  32'(s_rvalid),  0);
    chk("rst_resp",    32'({s_bresp, s_rresp}), 0);
    chk("rst_rdata",   32'(s_rdata), 0);
    chk("rst_regs",    32'(regs_flat), 0);
    rst = 1'b0;
    chk("rel_awready_pre", 32'(s_awready), 0);
    tick();
    chk("rel_readies", 32'({s_awready, s_wready, s_arready}), 32'h7);

    // AW+W same cycle, then read back
    issue(1, 0, 2'd2, 8'h04, 1'b1, 2'd0);
    chk("b_lat0", 32'(s_bvalid), 0);
    tick();
    chk("b_lat1", 32'(s_bvalid), 1);
    chk("regs_after_w2", 32'(regs_flat), 32'(mdl_flat()));
    wait_idle();
    issue(0, 1, 2'd0, 8'h00, 1'b0, 2'd2);
    wait_idle();

    // W leads AW by three cycles, B held off for five cycles
    s_bready = 1'b0;
    push_write(2'd1, 8'hA5, 1'b1);
    s_wdata = 8'hA5; s_wstrb = 1'b1; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    chk("wfirst_awready", 32'(s_awready), 1);
    chk("wfirst_wready",  32'(s_wready),  0);
    s_wdata = 8'h3C; s_wvalid = 1'b1;
    repeat (2) tick();
    s_wvalid = 1'b0;
    s_awaddr = 2'd1; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    wait_bvalid();
    for (int k = 0; k < 5; k++) begin
      chk("hold_bvalid", 32'(s_bvalid), 1);
      chk("hold_bresp",  32'(s_bresp),  0);
      chk("hold_readies", 32'({s_awready, s_wready}), 0);
      tick();
    end
    s_bready = 1'b1;
    wait_idle();
    chk("regs_reg1", 32'(regs_flat), 32'(mdl_flat()));

    // Zero strobe leaves the register alone
    issue(1, 0, 2'd0, 8'hFF, 1'b0, 2'd0);
    wait_idle();
    chk("regs_strb0", 32'(regs_flat), 32'(mdl_flat()));

    // Unmapped write and read
    issue(1, 0, 2'd3, 8'h77, 1'b1, 2'd0);
    wait_idle();
    issue(0, 1, 2'd0, 8'h00, 1'b0, 2'd3);
    wait_idle();
    chk("regs_unmapped", 32'(regs_flat), 32'(mdl_flat()));

    // Read and write to the same register committing on the same edge
    issue(1, 1, 2'd2, 8'h33, 1'b1, 2'd2);
    wait_idle();
    issue(0, 1, 2'd0, 8'h00, 1'b0, 2'd2);
    wait_idle();

    // Mixed random traffic
    for (int it = 0; it < 10; it++) begin
      int op;
      op = int'($urandom_range(0, 2));
      issue(op != 1, op != 0, 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom),
            2'($urandom_range(0, 3)));
      wait_idle();
      chk("regs_rand", 32'(regs_flat), 32'(mdl_flat()));
    end

    // Reset in the middle of a pending B response
    s_bready = 1'b0;
    issue(1, 0, 2'd0, 8'h5A, 1'b1, 2'd0);
    wait_bvalid();
    rst = 1'b1;
    #1;
    chk("midrst_bvalid", 32'(s_bvalid), 0);
    chk("midrst_awready", 32'(s_awready), 0);
    chk("midrst_regs", 32'(regs_flat), 0);
    qb.delete();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    tick();
    rst = 1'b0;
    s_bready = 1'b1;
    tick();
    chk("midrst_readies", 32'({s_awready, s_wready, s_arready}), 32'h7);
    issue(0, 1, 2'd0, 8'h00, 1'b0, 2'd0);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
